// File: rtl/pc_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the PC fetch unit: FSM state encoding, the
//   instruction word size, the reset/bubble instruction value and a helper
//   that forces a PC onto a word boundary.
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    TRAP  = 2'd3
  } fetch_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] INST_NOP   = 32'h0000_0000;

  // Clear the byte-offset bits so the PC always addresses a whole word.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~(32'(WORD_BYTES) - 32'd1);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_timeout_ctr.sv
// -----------------------------------------------------------------------------
// fetch_timeout_ctr
//   8-bit wait-cycle counter used while the fetch unit waits for imem_rvalid.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   en   in  count one more idle wait cycle
//   clr  in  return the count to zero (wins over en)
//   hit  out count has reached MAX_WAIT
// -----------------------------------------------------------------------------
module fetch_timeout_ctr
  import fetch_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic hit
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == 8'(MAX_WAIT));

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Holds the architectural PC, fetches the instruction at that PC from
//   instruction memory and presents {pc_o, inst_o} to decode with a
//   valid/ready handshake. On each accepted instruction the PC is reloaded
//   from nextpc_i (computed externally from pc_o/inst_o).
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   nextpc_i     next PC from the next-PC/branch logic
//   imem_req     one-cycle fetch request pulse, imem_addr = pc_o
//   imem_rvalid  / imem_rdata   instruction memory response
//   pc_o, inst_o, inst_valid, inst_ready   decode handshake
//   fetch_err    sticky: a fetch timed out since reset
//   inst_count   number of accepted instructions (wraps)
//   misalign     sticky misaligned-next-PC flag
//
// Build option: define PC_ALIGN_CHECK_EN to trap on a misaligned nextpc_i
// (PC loaded unmasked, misalign set, fetching stops until reset). Without it
// nextpc_i[1:0] is forced to zero and misalign is tied low.
// -----------------------------------------------------------------------------
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] nextpc_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_err,
  output logic [31:0] inst_count,
  output logic        misalign
);

  fetch_state_e state_q,      state_d;
  logic [31:0]  pc_q,         pc_d;
  logic [31:0]  inst_q,       inst_d;
  logic         inst_valid_q, inst_valid_d;
  logic         imem_req_q,   imem_req_d;
  logic         fetch_err_q,  fetch_err_d;
  logic [31:0]  inst_count_q, inst_count_d;
  logic         misalign_q,   misalign_d;

  logic tmo_en_s;
  logic tmo_clr_s;
  logic tmo_hit_s;
  logic accept_s;

  assign accept_s = inst_valid_q & inst_ready;

  fetch_timeout_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .en  (tmo_en_s),
    .clr (tmo_clr_s),
    .hit (tmo_hit_s)
  );

  // FSM next-state and datapath next values. The request flop is set on the
  // way into FETCH so the pulse coincides with the FETCH cycle; only the
  // first FETCH after reset spends an extra cycle raising it.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    imem_req_d   = 1'b0;
    fetch_err_d  = fetch_err_q;
    inst_count_d = inst_count_q;
    misalign_d   = misalign_q;
    tmo_en_s     = 1'b0;
    tmo_clr_s    = 1'b0;

    case (state_q)
      FETCH: begin
        if (imem_req_q) begin
          state_d   = WAIT;
          tmo_clr_s = 1'b1;
        end else begin
          imem_req_d = 1'b1;
        end
      end

      WAIT: begin
        // A response on the timeout cycle wins over the timeout.
        if (imem_rvalid) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
          state_d      = HOLD;
          tmo_clr_s    = 1'b1;
        end else if (tmo_hit_s) begin
          fetch_err_d = 1'b1;
          tmo_clr_s   = 1'b1;
          imem_req_d  = 1'b1;
          state_d     = FETCH;
        end else begin
          tmo_en_s = 1'b1;
        end
      end

      HOLD: begin
        if (accept_s) begin
          inst_count_d = inst_count_q + 32'd1;
          inst_valid_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
          if (nextpc_i[1:0] != 2'b00) begin
            pc_d       = nextpc_i;
            misalign_d = 1'b1;
            state_d    = TRAP;
          end else begin
            pc_d       = align_pc(nextpc_i);
            imem_req_d = 1'b1;
            state_d    = FETCH;
          end
`else
          pc_d       = align_pc(nextpc_i);
          imem_req_d = 1'b1;
          state_d    = FETCH;
`endif
        end else begin
          state_d = HOLD;
        end
      end

      TRAP: begin
`ifdef PC_ALIGN_CHECK_EN
        inst_valid_d = 1'b0;
        state_d      = TRAP;
`else
        // Unreachable in this build; fall back to fetching.
        inst_valid_d = 1'b0;
        state_d      = FETCH;
`endif
      end

      default: begin
        inst_valid_d = 1'b0;
        state_d      = FETCH;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= INST_NOP;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
      fetch_err_q  <= 1'b0;
      inst_count_q <= 32'd0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      imem_req_q   <= imem_req_d;
      fetch_err_q  <= fetch_err_d;
      inst_count_q <= inst_count_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign pc_o       = pc_q;
  assign inst_o     = inst_q;
  assign inst_valid = inst_valid_q;
  assign fetch_err  = fetch_err_q;
  assign inst_count = inst_count_q;
`ifdef PC_ALIGN_CHECK_EN
  assign misalign   = misalign_q;
`else
  assign misalign   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Directed bench for pc_fetch_unit. Expected {pc, inst} pairs are queued
//   when the bench answers a fetch and popped when decode accepts.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0040;
  localparam int unsigned MAXW   = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] nextpc_i;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_err;
  logic [31:0] inst_count;
  logic        misalign;

  pc_fetch_unit #(
    .RESET_PC (RST_PC),
    .MAX_WAIT (MAXW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .nextpc_i    (nextpc_i),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_o        (pc_o),
    .inst_o      (inst_o),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .fetch_err   (fetch_err),
    .inst_count  (inst_count),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  logic        exp_trap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, then check it targets the model PC.
  task automatic wait_req(input string tag);
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, exp_pc);
  endtask

  // Called on the request cycle: answer 'delay' cycles later.
  task automatic respond(input logic [31:0] data, input int delay);
    sb_q.push_back('{pc: exp_pc, inst: data});
    repeat (delay) cyc();
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    cyc();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
  endtask

  // Accept the held instruction with the given next PC and update the model.
  task automatic accept(input string tag, input logic [31:0] npc);
    exp_t e;
    int   n = 0;
    while (inst_valid !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else                 e = '{pc: 32'hFFFF_FFFF, inst: 32'hFFFF_FFFF};
    chk({tag, "_pc"}, pc_o, e.pc);
    chk({tag, "_inst"}, inst_o, e.inst);
    inst_ready = 1'b1;
    nextpc_i   = npc;
    cyc();
    inst_ready = 1'b0;
    exp_cnt    = exp_cnt + 32'd1;
`ifdef PC_ALIGN_CHECK_EN
    if (npc[1:0] != 2'b00) begin
      exp_pc   = npc;
      exp_trap = 1'b1;
    end else begin
      exp_pc = {npc[31:2], 2'b00};
    end
`else
    exp_pc = {npc[31:2], 2'b00};
`endif
    chk({tag, "_cnt"}, inst_count, exp_cnt);
    chk({tag, "_newpc"}, pc_o, exp_pc);
    chk({tag, "_dropvalid"}, {31'd0, inst_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    nextpc_i    = 32'd0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    inst_ready  = 1'b0;
    exp_pc      = RST_PC;
    exp_cnt     = 32'd0;
    exp_trap    = 1'b0;

    // T1: reset, then reset again while a fetch is outstanding.
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("t1_first_req", {31'd0, imem_req}, 32'd1);
    chk("t1_first_addr", imem_addr, RST_PC);
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("t1_rst_pc", pc_o, RST_PC);
    chk("t1_rst_inst", inst_o, 32'd0);
    chk("t1_rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("t1_rst_req", {31'd0, imem_req}, 32'd0);
    chk("t1_rst_err", {31'd0, fetch_err}, 32'd0);
    chk("t1_rst_cnt", inst_count, 32'd0);
    chk("t1_rst_mis", {31'd0, misalign}, 32'd0);
    sb_q.delete();
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("t1_req_after", {31'd0, imem_req}, 32'd1);
    chk("t1_addr_after", imem_addr, RST_PC);

    // T2: back-to-back stream; jump to 0 first, then 0, 4, 8 at one per 3 cycles.
    respond(32'h1111_0000, 1);
    accept("t2_jump", 32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      wait_req("t2_fetch");
      respond(32'hA000_0000 + 32'(i), 1);
      chk("t2_valid_at_n2", {31'd0, inst_valid}, 32'd1);
      chk("t2_pc_step", pc_o, 32'(i) * 32'd4);
      accept("t2_acc", exp_pc + 32'd4);
      chk("t2_next_req", {31'd0, imem_req}, 32'd1);
    end

    // T3: backpressure for 5 cycles; a stray rvalid during HOLD is ignored.
    wait_req("t3_fetch");
    respond(32'hB0B0_0003, 2);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("t3_hold_inst", inst_o, 32'hB0B0_0003);
      chk("t3_hold_pc", pc_o, 32'h0000_000C);
      chk("t3_no_req", {31'd0, imem_req}, 32'd0);
      if (i == 2) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_5555;
      end
      cyc();
      imem_rvalid = 1'b0;
    end
    accept("t3_acc", exp_pc + 32'd4);

    // T4: no response -> timeout, error flag, same-address re-request.
    wait_req("t4_fetch");
    repeat (14) cyc();
    chk("t4_err_early", {31'd0, fetch_err}, 32'd0);
    chk("t4_no_req_early", {31'd0, imem_req}, 32'd0);
    wait_req("t4_rereq");
    chk("t4_err_set", {31'd0, fetch_err}, 32'd1);
    respond(32'hC0DE_0004, 1);
    accept("t4_acc", exp_pc + 32'd4);
    chk("t4_err_sticky", {31'd0, fetch_err}, 32'd1);

    // T5: inst_count wraps from all-ones to zero.
    wait_req("t5_fetch");
    cyc();
    force dut.inst_count_q = 32'hFFFF_FFFF;
    cyc();
    release dut.inst_count_q;
    exp_cnt = 32'hFFFF_FFFF;
    respond(32'hE000_0005, 1);
    accept("t5_acc", exp_pc + 32'd4);
    chk("t5_wrap", inst_count, 32'd0);

    // T6: misaligned next PC.
    wait_req("t6_fetch");
    respond(32'hD00D_0006, 1);
    accept("t6_acc", 32'h0000_0102);
`ifdef PC_ALIGN_CHECK_EN
    chk("t6_pc_raw", pc_o, 32'h0000_0102);
    chk("t6_mis", {31'd0, misalign}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("t6_trap_noreq", {31'd0, imem_req}, 32'd0);
      chk("t6_trap_novalid", {31'd0, inst_valid}, 32'd0);
      cyc();
    end
`else
    chk("t6_pc_masked", pc_o, 32'h0000_0100);
    chk("t6_mis_zero", {31'd0, misalign}, 32'd0);
    wait_req("t6_cont");
    respond(32'hF00D_0007, 1);
    accept("t6_cont_acc", exp_pc + 32'd4);
`endif
    chk("t6_err_sticky", {31'd0, fetch_err}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
